// File: rtl/ap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ap_ctrl_pkg
// Shared types for the ap_ctrl_hs initiator slice.
//   state_t        : driver FSM state (idle, issuing, draining, finished)
//   DEFAULT_CNT_W  : default width of transaction, cycle and latency counters
// ---------------------------------------------------------------------------
package ap_ctrl_pkg;

  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ap_ts_fifo.sv
// ---------------------------------------------------------------------------
// ap_ts_fifo
// Circular FIFO holding the issue timestamp of every outstanding kernel
// transaction. Full/empty come from read/write pointers carrying one extra
// wrap bit, so all DEPTH entries are usable.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-low reset
//   flush          : synchronous clear of both pointers (wins over push/pop)
//   push, din      : write din when not full (or when a pop frees a slot)
//   pop            : discard head when not empty
//   head           : oldest stored entry
//   full, empty    : occupancy flags
// ---------------------------------------------------------------------------
module ap_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written, so push-when-full is legal then.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; the wrap bit distinguishes full from empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// ---------------------------------------------------------------------------
// ap_ctrl_hs_driver
// Initiator for the ap_ctrl_hs block-level handshake. Issues a programmed
// number of kernel starts, keeps at most MAX_OUTSTANDING accepted-but-not-done
// transactions in flight, and measures each transaction's latency from accept
// to done.
// Ports:
//   clock, reset              : rising-edge clock, asynchronous active-low reset
//   cfg_go, cfg_num_txn       : start pulse and transaction count for a run
//   ap_start / ap_ready       : start request / kernel accepted it
//   ap_done / ap_idle         : per-transaction completion / kernel idle
//   ap_continue               : 1 whenever out of reset
//   busy, finish              : run in progress / run complete (held)
//   txn_issued, txn_done      : accepts and completions this run
//   last_latency, max_latency : latency of the latest completion / run maximum
//   err_spurious              : sticky, ap_done with nothing outstanding
// ---------------------------------------------------------------------------
import ap_ctrl_pkg::*;

module ap_ctrl_hs_driver #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_go,
  input  logic [CNT_W-1:0] cfg_num_txn,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] txn_issued,
  output logic [CNT_W-1:0] txn_done,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic             err_spurious
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] num_txn;
  logic [CNT_W-1:0] fifo_head;
  logic [CNT_W-1:0] latency;
  logic             fifo_full;
  logic             fifo_empty;
  logic             go_ok;
  logic             active;
  logic             accept;
  logic             complete;

  assign active      = (state == ST_RUN) || (state == ST_DRAIN);
  assign go_ok       = cfg_go && ((state == ST_IDLE) || (state == ST_FINISH));
  assign accept      = ap_start && ap_ready;
  // A done only counts when there is a timestamp to pair it with.
  assign complete    = ap_done && active && !fifo_empty;
  // Modular subtraction keeps the latency correct across a cycle_cnt wrap.
  assign latency     = cycle_cnt - fifo_head;
  assign ap_continue = reset;

  ap_ts_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (CNT_W)
  ) u_ts_fifo (
    .clock (clock),
    .reset (reset),
    .flush (go_ok),
    .push  (accept),
    .pop   (complete),
    .din   (cycle_cnt),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs. ap_start is also gated by the issue
  // count so it drops in the cycle right after the last accept, before the
  // FSM has moved on to DRAIN.
  always_comb begin
    state_nxt = state;
    ap_start  = 1'b0;
    busy      = active;
    finish    = (state == ST_FINISH);
    case (state)
      ST_IDLE, ST_FINISH: begin
        if (cfg_go) state_nxt = (cfg_num_txn == '0) ? ST_FINISH : ST_RUN;
      end
      ST_RUN: begin
        ap_start = !fifo_full && (txn_issued != num_txn);
        if (txn_issued == num_txn) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((txn_done == num_txn) && ap_idle) state_nxt = ST_FINISH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Free-running cycle counter used as the timestamp source.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

  // Run counters, latency tracking and the spurious-done flag. An accepted
  // cfg_go starts a clean run and takes priority over everything else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      num_txn      <= '0;
      txn_issued   <= '0;
      txn_done     <= '0;
      last_latency <= '0;
      max_latency  <= '0;
      err_spurious <= 1'b0;
    end else if (go_ok) begin
      num_txn      <= cfg_num_txn;
      txn_issued   <= '0;
      txn_done     <= '0;
      last_latency <= '0;
      max_latency  <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (accept) txn_issued <= txn_issued + CNT_W'(1);
      if (complete) begin
        txn_done     <= txn_done + CNT_W'(1);
        last_latency <= latency;
        if (latency > max_latency) max_latency <= latency;
      end
      if (ap_done && !complete) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_hs_driver
// Drives ap_ctrl_hs_driver with a small kernel model (per-transaction
// latency and ready-delay lists) and checks its status outputs against
// hand-computed expectations queued by the stimulus process.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_hs_driver;

  localparam int MAXO = 4;
  localparam int W    = 32;

  logic         clock       = 1'b0;
  logic         reset       = 1'b1;
  logic         cfg_go      = 1'b0;
  logic [W-1:0] cfg_num_txn = '0;
  logic         ap_ready    = 1'b0;
  logic         ap_done     = 1'b0;
  logic         ap_idle     = 1'b1;
  logic         ap_start;
  logic         ap_continue;
  logic         busy;
  logic         finish;
  logic [W-1:0] txn_issued;
  logic [W-1:0] txn_done;
  logic [W-1:0] last_latency;
  logic [W-1:0] max_latency;
  logic         err_spurious;

  ap_ctrl_hs_driver #(
    .MAX_OUTSTANDING (MAXO),
    .CNT_W           (W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_go       (cfg_go),
    .cfg_num_txn  (cfg_num_txn),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_continue  (ap_continue),
    .busy         (busy),
    .finish       (finish),
    .txn_issued   (txn_issued),
    .txn_done     (txn_done),
    .last_latency (last_latency),
    .max_latency  (max_latency),
    .err_spurious (err_spurious)
  );

  always #5 clock = ~clock;

  // Expected completion: txn_done value, last_latency, max_latency after it.
  typedef struct {
    int done;
    int last;
    int maxl;
  } cmp_t;

  // Expected end-of-run snapshot; lag/span of -1 means not checked.
  typedef struct {
    int issued;
    int done;
    int maxl;
    int peak;
    int lag;
    int span;
  } fin_t;

  cmp_t cmp_q[$];
  fin_t fin_q[$];
  int   err_q[$];

  int   checks   = 0;
  int   failures = 0;
  bit   tb_done  = 1'b0;

  // Kernel model state (stimulus process only).
  int   ncyc     = 0;
  int   kern_out = 0;
  int   wait_cnt = 0;
  bit   kern_en  = 1'b0;
  bit   spur_req = 1'b0;
  bit   done_map [1024];
  int   lat_q[$];
  int   dly_q[$];

  // Monitor state (monitor process only).
  int           mcyc;
  int           go_cyc;
  int           first_iss;
  int           last_iss;
  logic [W-1:0] peak;
  logic [W-1:0] pdone;
  logic [W-1:0] piss;
  logic         pbusy;
  logic         pfin;
  logic         perr;
  logic         in_reset;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One kernel cycle, evaluated at the falling edge: present dones that are
  // due, set ap_ready, and schedule a done for any accept at the next edge.
  task automatic stepCycle();
    int slot;
    int lat;
    @(negedge clock);
    ncyc++;
    slot    = ncyc % 1024;
    ap_done = done_map[slot] || spur_req;
    if (done_map[slot]) kern_out--;
    done_map[slot] = 1'b0;
    spur_req       = 1'b0;
    if (wait_cnt > 0) begin
      ap_ready = 1'b0;
      wait_cnt--;
    end else begin
      ap_ready = kern_en;
    end
    if (ap_start && ap_ready && reset) begin
      lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      done_map[(ncyc + lat) % 1024] = 1'b1;
      kern_out++;
      wait_cnt = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
    end
    ap_idle = (kern_out == 0);
  endtask

  task automatic applyStimulus(input int num);
    cfg_num_txn = W'(num);
    cfg_go      = 1'b1;
    stepCycle();
    cfg_go      = 1'b0;
  endtask

  task automatic waitFinish();
    for (int i = 0; i < 400 && finish !== 1'b1; i++) stepCycle();
    stepCycle();
  endtask

  task automatic clearKernel();
    for (int i = 0; i < 1024; i++) done_map[i] = 1'b0;
    kern_out = 0;
    wait_cnt = 0;
    lat_q.delete();
    dly_q.delete();
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    ap_idle  = 1'b1;
  endtask

  // Stimulus: directed scenarios, each queuing its expected responses first.
  initial begin : stimulus
    clearKernel();
    #2 reset = 1'b0;
    repeat (2) stepCycle();
    reset = 1'b1;
    stepCycle();

    // Spurious done while idle.
    err_q.push_back(0);
    spur_req = 1'b1;
    stepCycle();
    stepCycle();

    // Fixed latency 5, three back-to-back accepts.
    kern_en = 1'b1;
    lat_q   = '{5, 5, 5};
    for (int i = 1; i <= 3; i++) cmp_q.push_back('{i, 5, 5});
    fin_q.push_back('{3, 3, 5, 3, -1, 2});
    applyStimulus(3);
    waitFinish();

    // Slow kernel: throttled at four outstanding.
    lat_q = '{20, 20, 20, 20, 20, 20, 20, 20};
    for (int i = 1; i <= 8; i++) cmp_q.push_back('{i, 20, 20});
    fin_q.push_back('{8, 8, 20, 4, -1, -1});
    applyStimulus(8);
    waitFinish();

    // Done of txn0 collides with accept of txn1.
    lat_q = '{3, 7};
    dly_q = '{2};
    cmp_q.push_back('{1, 3, 3});
    cmp_q.push_back('{2, 7, 7});
    fin_q.push_back('{2, 2, 7, 1, -1, 3});
    applyStimulus(2);
    waitFinish();

    // Zero-length run.
    fin_q.push_back('{0, 0, 0, 0, 0, -1});
    applyStimulus(0);
    waitFinish();

    // Reset mid-run with two transactions outstanding.
    lat_q = '{30, 30, 30, 30};
    dly_q = '{0, 100};
    applyStimulus(4);
    repeat (4) stepCycle();
    #1 reset = 1'b0;
    clearKernel();
    repeat (2) stepCycle();
    reset = 1'b1;
    stepCycle();

    // Clean run after reset.
    lat_q = '{4, 4};
    cmp_q.push_back('{1, 4, 4});
    cmp_q.push_back('{2, 4, 4});
    fin_q.push_back('{2, 2, 4, 2, -1, 1});
    applyStimulus(2);
    waitFinish();

    repeat (3) stepCycle();
    tb_done = 1'b1;
    repeat (10) @(negedge clock);
    $display("[TB] FAIL watchdog: monitor did not reach its summary");
    $fatal(1, "[TB] monitor stalled");
  end

  task automatic clearMonitor();
    pbusy     = 1'b0;
    pfin      = 1'b0;
    perr      = 1'b0;
    pdone     = '0;
    piss      = '0;
    peak      = '0;
    first_iss = -1;
    last_iss  = -1;
  endtask

  // Per-cycle observation, sampled 2 time units after the rising edge.
  task automatic monitorCycle();
    logic         go_acc;
    logic [W-1:0] out_now;
    cmp_t         e;
    fin_t         f;
    mcyc++;
    go_acc  = cfg_go && !pbusy;
    out_now = txn_issued - txn_done;
    if (go_acc) begin
      go_cyc    = mcyc;
      peak      = '0;
      first_iss = -1;
      last_iss  = -1;
      checkOutput("go_err_cleared", err_spurious, 0);
      checkOutput("go_counters_cleared", txn_issued | txn_done | max_latency | last_latency, 0);
      checkOutput("go_ap_continue", ap_continue, 1);
    end
    if (busy) begin
      checkOutput("outstanding_le_max", (out_now <= W'(MAXO)) ? 1 : 0, 1);
      if (out_now > peak) peak = out_now;
    end
    if (txn_issued != piss && txn_issued != '0) begin
      if (first_iss < 0) first_iss = mcyc;
      last_iss = mcyc;
    end
    if (txn_done == pdone + 32'd1) begin
      if (cmp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_completion: got txn_done=%0d, expected none", txn_done);
      end else begin
        e = cmp_q.pop_front();
        checkOutput("cmp_txn_done", txn_done, e.done);
        checkOutput("cmp_last_latency", last_latency, e.last);
        checkOutput("cmp_max_latency", max_latency, e.maxl);
      end
    end
    if (err_spurious && !perr) begin
      if (err_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_err_spurious: got 1, expected 0");
      end else begin
        checkOutput("err_txn_done", txn_done, err_q.pop_front());
      end
    end
    if (finish && (!pfin || go_acc)) begin
      if (fin_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_finish: got finish=1, expected 0");
      end else begin
        f = fin_q.pop_front();
        checkOutput("fin_txn_issued", txn_issued, f.issued);
        checkOutput("fin_txn_done", txn_done, f.done);
        checkOutput("fin_max_latency", max_latency, f.maxl);
        checkOutput("fin_busy", busy, 0);
        checkOutput("fin_peak_outstanding", peak, f.peak);
        if (f.lag >= 0)  checkOutput("fin_lag_after_go", mcyc - go_cyc, f.lag);
        if (f.span >= 0) checkOutput("fin_issue_span", last_iss - first_iss, f.span);
      end
    end
    pbusy = busy;
    pfin  = finish;
    perr  = err_spurious;
    pdone = txn_done;
    piss  = txn_issued;
  endtask

  // Monitor: the only process that compares; reports the summary.
  initial begin : monitor
    mcyc     = 0;
    go_cyc   = 0;
    in_reset = 1'b0;
    clearMonitor();
    forever begin
      @(posedge clock or negedge reset);
      if (tb_done) break;
      if (!reset) begin
        if (!in_reset) begin
          in_reset = 1'b1;
          #1;
          checkOutput("reset_flags", {ap_start, busy, finish, err_spurious, ap_continue}, 0);
          checkOutput("reset_counters", txn_issued | txn_done | last_latency | max_latency, 0);
          clearMonitor();
        end
      end else begin
        in_reset = 1'b0;
        #2;
        monitorCycle();
      end
    end
    checkOutput("pending_completions", cmp_q.size(), 0);
    checkOutput("pending_finishes", fin_q.size(), 0);
    checkOutput("pending_errors", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
